// File: rtl/lc3b_types.sv
// LC-3b shared datapath types.
// Register specifiers used by hazard logic.
package lc3b_types;
  typedef logic [2:0] lc3b_reg;
endpackage

// File: rtl/pipeline_ctrl_pkg.sv
// Pipeline controller shared definitions.
// FSM encoding and counter defaults.
package pipeline_ctrl_pkg;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    RUN,
    HOLD_I,
    HOLD_D
  } lc3b_pipe_state;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Memory handshake bundle between the
// datapath/memories and the controller.
interface pipeline_ctrl_if;
  logic imem_read;
  logic imem_resp;
  logic dmem_req;
  logic dmem_resp;
  logic imem_mask;
  logic dmem_mask;
  logic ibuf_load;
  logic dbuf_load;
  logic ibuf_sel;
  logic dbuf_sel;

  modport master (
    output imem_read, imem_resp,
    output dmem_req, dmem_resp,
    input  imem_mask, dmem_mask,
    input  ibuf_load, dbuf_load,
    input  ibuf_sel, dbuf_sel
  );

  modport slave (
    input  imem_read, imem_resp,
    input  dmem_req, dmem_resp,
    output imem_mask, dmem_mask,
    output ibuf_load, dbuf_load,
    output ibuf_sel, dbuf_sel
  );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard compare between the load
// in EX and the source operands in ID.
module load_use_detect
  import lc3b_types::*;
(
  input  logic    ex_mem_read,
  input  lc3b_reg ex_dr,
  input  lc3b_reg id_sr1,
  input  lc3b_reg id_sr2,
  input  logic    id_uses_sr1,
  input  logic    id_uses_sr2,
  output logic    load_use
);
  logic hit1;
  logic hit2;

  // A used source matching the load target needs the loaded value
  always_comb begin
    hit1 = id_uses_sr1 & (id_sr1 == ex_dr);
    hit2 = id_uses_sr2 & (id_sr2 == ex_dr);
    load_use = ex_mem_read & (hit1 | hit2);
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage
// LC-3b pipeline with split-response holding.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
  import lc3b_types::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   mem,
  input  logic             ex_mem_read,
  input  lc3b_reg          ex_dr,
  input  lc3b_reg          id_sr1,
  input  lc3b_reg          id_sr2,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic             br_taken,
  input  logic             stat_clear,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             if_id_reset,
  output logic             id_reset,
  output logic             ex_reset,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  lc3b_pipe_state state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic load_use;
  logic i_ok, d_ok, advance;
  logic stall_inc, flush_inc;
  logic imask, dmask, iload, dload, isel, dsel;

  load_use_detect u_lud (
    .ex_mem_read (ex_mem_read),
    .ex_dr       (ex_dr),
    .id_sr1      (id_sr1),
    .id_sr2      (id_sr2),
    .id_uses_sr1 (id_uses_sr1),
    .id_uses_sr2 (id_uses_sr2),
    .load_use    (load_use)
  );

  // A side is satisfied when idle, answered now, or already held
  always_comb begin
    i_ok = ~mem.imem_read | mem.imem_resp
         | (state_q == HOLD_I);
    d_ok = ~mem.dmem_req | mem.dmem_resp
         | (state_q == HOLD_D);
    advance = i_ok & d_ok;
  end

  // Next state plus stage loads, flushes and buffer control
  always_comb begin
    state_d     = state_q;
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    if_id_reset = 1'b0;
    id_reset    = 1'b0;
    ex_reset    = 1'b0;
    imask       = 1'b0;
    dmask       = 1'b0;
    iload       = 1'b0;
    dload       = 1'b0;
    isel        = 1'b0;
    dsel        = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (!advance) begin
          if (mem.imem_resp) begin
            iload   = 1'b1;
            state_d = HOLD_I;
          end else if (mem.dmem_resp) begin
            dload   = 1'b1;
            state_d = HOLD_D;
          end
        end
      end
      HOLD_I: begin
        imask = 1'b1;
        isel  = 1'b1;
        if (advance) state_d = RUN;
      end
      HOLD_D: begin
        dmask = 1'b1;
        dsel  = 1'b1;
        if (advance) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (advance) begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (br_taken) begin
        if_id_reset = 1'b1;
        id_reset    = 1'b1;
        ex_reset    = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        load_pc    = 1'b0;
        load_if_id = 1'b0;
        id_reset   = 1'b1;
        stall_inc  = 1'b1;
      end
    end else begin
      stall_inc = 1'b1;
    end

    if (reset) begin
      state_d     = RUN;
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      if_id_reset = 1'b0;
      id_reset    = 1'b0;
      ex_reset    = 1'b0;
      imask       = 1'b0;
      dmask       = 1'b0;
      iload       = 1'b0;
      dload       = 1'b0;
      isel        = 1'b0;
      dsel        = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
    end
  end

  assign mem.imem_mask = imask;
  assign mem.dmem_mask = dmask;
  assign mem.ibuf_load = iload;
  assign mem.dbuf_load = dload;
  assign mem.ibuf_sel  = isel;
  assign mem.dbuf_sel  = dsel;

  // Saturating statistics; clear wins over increment
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stat_clear) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stall_inc && stall_q != '1)
        stall_d = stall_q + CNT_W'(1);
      if (flush_inc && flush_q != '1)
        flush_d = flush_q + CNT_W'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl:
// vector table, directed sequences, random.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if mif ();

  logic       ex_mem_read;
  logic [2:0] ex_dr, id_sr1, id_sr2;
  logic       id_uses_sr1, id_uses_sr2;
  logic       br_taken, stat_clear;
  logic       load_pc, load_if_id, load_id_ex;
  logic       load_ex_mem, load_mem_wb;
  logic       if_id_reset, id_reset, ex_reset;
  logic [15:0] stall_count, flush_count;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (mif),
    .ex_mem_read (ex_mem_read),
    .ex_dr       (ex_dr),
    .id_sr1      (id_sr1),
    .id_sr2      (id_sr2),
    .id_uses_sr1 (id_uses_sr1),
    .id_uses_sr2 (id_uses_sr2),
    .br_taken    (br_taken),
    .stat_clear  (stat_clear),
    .load_pc     (load_pc),
    .load_if_id  (load_if_id),
    .load_id_ex  (load_id_ex),
    .load_ex_mem (load_ex_mem),
    .load_mem_wb (load_mem_wb),
    .if_id_reset (if_id_reset),
    .id_reset    (id_reset),
    .ex_reset    (ex_reset),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  int checks = 0;
  int errors = 0;

  // model: which side's response is parked (0 none, 1 instr, 2 data)
  int held = 0;
  int m_stall = 0;
  int m_flush = 0;

  localparam logic [13:0] ALL_LD = 14'b11111_000_000000;
  localparam logic [13:0] BUBBLE = 14'b00111_010_000000;
  localparam logic [13:0] FLUSH  = 14'b11111_111_000000;
  localparam logic [13:0] FROZEN = 14'b00000_000_000000;

  typedef struct {
    logic       ir, irs, dr, drs, exr;
    logic [2:0] xd, s1, s2;
    logic       u1, u2, br;
    logic [13:0] exp;
  } vec_t;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [13:0] outs();
    return {load_pc, load_if_id, load_id_ex,
            load_ex_mem, load_mem_wb,
            if_id_reset, id_reset, ex_reset,
            mif.imem_mask, mif.dmem_mask,
            mif.ibuf_load, mif.dbuf_load,
            mif.ibuf_sel, mif.dbuf_sel};
  endfunction

  task automatic model(output logic [13:0] e,
                       output int nxt,
                       output bit si, output bit fi);
    bit iok, dok, adv, lu;
    iok = !mif.imem_read || mif.imem_resp || held == 1;
    dok = !mif.dmem_req || mif.dmem_resp || held == 2;
    adv = iok && dok;
    lu = ex_mem_read &&
         ((id_uses_sr1 && id_sr1 == ex_dr) ||
          (id_uses_sr2 && id_sr2 == ex_dr));
    e = FROZEN; nxt = held; si = 0; fi = 0;
    if (adv) begin
      nxt = 0;
      if (br_taken) begin e = FLUSH; fi = 1; end
      else if (lu) begin e = BUBBLE; si = 1; end
      else e = ALL_LD;
    end else begin
      si = 1;
      if (held == 0 && mif.imem_resp) begin
        e[3] = 1'b1; nxt = 1;
      end else if (held == 0 && mif.dmem_resp) begin
        e[2] = 1'b1; nxt = 2;
      end
    end
    if (held == 1) begin e[5] = 1'b1; e[1] = 1'b1; end
    if (held == 2) begin e[4] = 1'b1; e[0] = 1'b1; end
    if (reset) e = FROZEN;
  endtask

  // inputs set after posedge; check at negedge; model steps at posedge
  task automatic step(string nm);
    logic [13:0] e; int nxt; bit si, fi;
    @(negedge clk);
    if (reset) begin held = 0; m_stall = 0; m_flush = 0; end
    model(e, nxt, si, fi);
    chk({nm, " outs"}, 32'(outs()), 32'(e));
    chk({nm, " stall"}, 32'(stall_count), m_stall);
    chk({nm, " flush"}, 32'(flush_count), m_flush);
    @(posedge clk);
    if (reset) begin
      held = 0; m_stall = 0; m_flush = 0;
    end else begin
      held = nxt;
      if (stat_clear) begin m_stall = 0; m_flush = 0; end
      else begin
        if (si && m_stall < 65535) m_stall++;
        if (fi && m_flush < 65535) m_flush++;
      end
    end
    #1;
  endtask

  task automatic idle();
    mif.imem_read = 0; mif.imem_resp = 0;
    mif.dmem_req = 0;  mif.dmem_resp = 0;
    ex_mem_read = 0; ex_dr = 0; id_sr1 = 0; id_sr2 = 0;
    id_uses_sr1 = 0; id_uses_sr2 = 0;
    br_taken = 0; stat_clear = 0;
  endtask

  task automatic clear_stats();
    stat_clear = 1; step("clr"); stat_clear = 0;
  endtask

  vec_t tbl[12];

  initial begin
    idle();
    reset = 1;
    #1;
    step("reset");
    chk("reset outs", 32'(outs()), 32'(FROZEN));
    reset = 0;

    tbl[0]  = '{0,0,0,0, 0,0,0,0, 0,0,0, ALL_LD};
    tbl[1]  = '{1,0,0,0, 0,0,0,0, 0,0,0, FROZEN};
    tbl[2]  = '{1,1,0,0, 0,0,0,0, 0,0,0, ALL_LD};
    tbl[3]  = '{0,0,1,0, 0,0,0,0, 0,0,0, FROZEN};
    tbl[4]  = '{1,1,1,1, 0,0,0,0, 0,0,0, ALL_LD};
    tbl[5]  = '{0,0,0,0, 1,5,5,0, 1,0,0, BUBBLE};
    tbl[6]  = '{0,0,0,0, 1,5,5,0, 0,0,0, ALL_LD};
    tbl[7]  = '{0,0,0,0, 1,3,0,3, 0,1,0, BUBBLE};
    tbl[8]  = '{0,0,0,0, 0,3,3,3, 1,1,0, ALL_LD};
    tbl[9]  = '{0,0,0,0, 1,2,2,2, 1,1,1, FLUSH};
    tbl[10] = '{1,0,0,0, 0,0,0,0, 0,0,1, FROZEN};
    tbl[11] = '{0,0,0,0, 0,0,0,0, 0,0,1, FLUSH};
    for (int i = 0; i < 12; i++) begin
      mif.imem_read = tbl[i].ir; mif.imem_resp = tbl[i].irs;
      mif.dmem_req = tbl[i].dr;  mif.dmem_resp = tbl[i].drs;
      ex_mem_read = tbl[i].exr; ex_dr = tbl[i].xd;
      id_sr1 = tbl[i].s1; id_sr2 = tbl[i].s2;
      id_uses_sr1 = tbl[i].u1; id_uses_sr2 = tbl[i].u2;
      br_taken = tbl[i].br;
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      step($sformatf("vec%0d", i));
    end
    idle();

    // imem latency of 3 cycles
    clear_stats();
    mif.imem_read = 1;
    repeat (3) step("ilat");
    mif.imem_resp = 1;
    #2 chk("ilat resp load_pc", 32'(load_pc), 1);
    step("ilat");
    idle();
    chk("ilat stall_count", 32'(stall_count), 3);

    // split responses: imem first, dmem 3 cycles later
    mif.imem_read = 1; mif.dmem_req = 1;
    step("split0");
    mif.imem_resp = 1;
    #2 chk("split ibuf_load", 32'(mif.ibuf_load), 1);
    step("split1");
    mif.imem_resp = 0;
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) mif.dmem_resp = 1;
      #2 chk($sformatf("split%0d mask", c),
             32'({mif.imem_mask, mif.ibuf_sel}), 32'(2'b11));
      if (c == 4)
        chk("split4 adv", 32'(load_mem_wb), 1);
      step($sformatf("split%0d", c));
    end
    idle();
    #2 chk("split run", 32'(mif.imem_mask), 0);

    // load-use on sr2
    clear_stats();
    ex_mem_read = 1; ex_dr = 3; id_sr2 = 3; id_uses_sr2 = 1;
    #2 chk("lu outs", 32'(outs()), 32'(BUBBLE));
    step("lu");
    idle();
    chk("lu stall_count", 32'(stall_count), 1);

    // branch overrides load-use
    clear_stats();
    ex_mem_read = 1; ex_dr = 3; id_sr1 = 3; id_uses_sr1 = 1;
    br_taken = 1;
    #2 chk("brlu outs", 32'(outs()), 32'(FLUSH));
    step("brlu");
    idle();
    chk("brlu flush", 32'(flush_count), 1);
    chk("brlu stall", 32'(stall_count), 0);

    // branch held during a 2-cycle dmem stall
    mif.dmem_req = 1; br_taken = 1;
    repeat (2) begin
      #2 chk("brst resets",
             32'({if_id_reset, id_reset, ex_reset}), 0);
      step("brst");
    end
    mif.dmem_resp = 1;
    #2 chk("brst flush", 32'({if_id_reset, id_reset, ex_reset}), 7);
    step("brst");
    idle();

    // saturation and clear
    clear_stats();
    mif.imem_read = 1;
    repeat (65537) step("sat");
    chk("sat stall_count", 32'(stall_count), 32'hFFFF);
    stat_clear = 1;
    step("satclr");
    stat_clear = 0;
    chk("sat cleared", 32'(stall_count), 0);
    idle();

    // reset while holding data response
    mif.imem_read = 1; mif.dmem_req = 1; mif.dmem_resp = 1;
    step("hd0");
    mif.dmem_resp = 0;
    #2 chk("hd mask", 32'(mif.dmem_mask), 1);
    step("hd1");
    reset = 1;
    #2 chk("hd reset outs", 32'(outs()), 32'(FROZEN));
    chk("hd reset stall", 32'(stall_count), 0);
    step("hd rst");
    reset = 0;
    idle();
    #2 chk("hd after", 32'(outs()), 32'(ALL_LD));
    step("hd after");

    // randomized against the model
    for (int n = 0; n < 3000; n++) begin
      mif.imem_read = 1'($urandom_range(0, 1));
      mif.imem_resp = ($urandom_range(0, 3) == 0);
      mif.dmem_req  = 1'($urandom_range(0, 1));
      mif.dmem_resp = ($urandom_range(0, 3) == 0);
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_dr  = 3'($urandom_range(0, 3));
      id_sr1 = 3'($urandom_range(0, 3));
      id_sr2 = 3'($urandom_range(0, 3));
      id_uses_sr1 = 1'($urandom_range(0, 1));
      id_uses_sr2 = 1'($urandom_range(0, 1));
      br_taken = ($urandom_range(0, 4) == 0);
      stat_clear = ($urandom_range(0, 60) == 0);
      reset = ($urandom_range(0, 120) == 0);
      step("rnd");
      reset = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall/flush sequencer for the five-stage LC-3b pipeline. It drives the load enables and flush resets of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It freezes the pipeline while instruction or data memory is outstanding, and it collects split memory responses across cycles through one-entry holding buffers. It inserts load-use bubbles and flushes wrong-path instructions on a taken branch, and it keeps saturating stall and flush statistics.

## Interface
Parameters:
- CNT_W, 16, width of statistic counters

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- imem_read  in  1  IF stage requesting instruction fetch
- imem_resp  in  1  instruction memory response, one-cycle pulse
- dmem_req  in  1  MEM stage read or write request
- dmem_resp  in  1  data memory response, one-cycle pulse
- ex_mem_read  in  1  instruction in EX is a load
- ex_dr  in  3  destination register (lc3b_reg) of the instruction in EX
- id_sr1, id_sr2  in  3 each  source registers of the instruction in ID
- id_uses_sr1, id_uses_sr2  in  1 each  source operand valid
- br_taken  in  1  taken branch/jump resolved in MEM
- stat_clear  in  1  synchronous clear of the counters
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage register loads
- if_id_reset, id_reset, ex_reset  out  1 each  flush of IF/ID, ID/EX, EX/MEM; only effective with the matching load=1
- imem_mask, dmem_mask  out  1 each  suppress re-issue of an already-answered request
- ibuf_load, dbuf_load  out  1 each  capture the response into the holding buffer
- ibuf_sel, dbuf_sel  out  1 each  stage consumes the holding buffer instead of memory data
- stall_count, flush_count  out  CNT_W each  saturating statistics

## Operation
- i_ok = ~imem_read | imem_resp | (state==HOLD_I); d_ok = ~dmem_req | dmem_resp | (state==HOLD_D).
- advance = i_ok & d_ok. When advance=0, every load_* is 0 and every reset is 0.
- FSM states:
  - RUN (reset state):
    - i_ok & d_ok: advance, stay in RUN.
    - imem_resp & ~d_ok: ibuf_load=1, go to HOLD_I.
    - dmem_resp & ~i_ok: dbuf_load=1, go to HOLD_D.
    - otherwise: stay in RUN.
  - HOLD_I: imem_mask=1, ibuf_sel=1. On dmem_resp, advance and go to RUN. Otherwise stay.
  - HOLD_D: dmem_mask=1, dbuf_sel=1. On imem_resp, advance and go to RUN. Otherwise stay.
- load_use = ex_mem_read & ((id_uses_sr1 & id_sr1==ex_dr) | (id_uses_sr2 & id_sr2==ex_dr)).
- Outcomes when advance=1, in priority order:
  - br_taken: all loads 1; if_id_reset, id_reset and ex_reset all 1. This flushes the three younger instructions, and load_use is ignored.
  - load_use: load_pc=0, load_if_id=0, load_id_ex=1 with id_reset=1 (bubble); load_ex_mem=1, load_mem_wb=1.
  - otherwise: all loads 1, no resets.
- stall_count increments in every cycle where advance=0, and in every advancing load_use cycle without br_taken.
- flush_count increments in every advancing br_taken cycle.
- Both counters saturate at all-ones. stat_clear zeroes both and has priority over increment.

## Timing
- Control outputs are combinational from the inputs and state, with zero latency. State and counters update on posedge clk.
- A response arriving in the same cycle as its request counts as ok; there is no added latency.
- imem_resp and dmem_resp arriving in the same cycle in RUN: advance, stay in RUN, no buffer load.
- A response pulse for the already-held side while in HOLD_x is ignored. The mask keeps that request from being re-issued.
- br_taken during a freeze has no effect until the advancing cycle. The branch stays in MEM, so br_taken remains asserted.
- While reset is high: state=RUN, counters=0, and all load_*, *_reset, *_mask, *_buf_load and *_buf_sel outputs are forced to 0. Reset mid-HOLD abandons the held data.
- Counter saturation: at all-ones, the counter holds its value and does not wrap.

## Structure
- A shared package holds an lc3b_pipe_state enum {RUN, HOLD_I, HOLD_D} and a CNT_W default constant. lc3b_reg comes from lc3b_types.
- The hazard compare is split into a natural sub-module, load_use_detect (purely combinational). The FSM and counters stay in pipeline_ctrl.

## Test plan
- imem_read=1 with imem_resp 3 cycles later and dmem_req=0 → all loads 0 for 3 cycles, load=1 on the resp cycle, stall_count=3.
- dmem_req and imem_read both high; imem_resp in cycle 1, dmem_resp in cycle 4 → ibuf_load in cycle 1, HOLD_I with imem_mask and ibuf_sel in cycles 2–4, advance in cycle 4, then RUN.
- ex_mem_read=1, ex_dr=3, id_sr2=3, id_uses_sr2=1, no stalls → one cycle with load_pc=0, load_if_id=0, id_reset=1, load_id_ex=1; stall_count +1.
- br_taken=1 together with a load_use match → full flush (three resets), load_pc=1, flush_count=1, stall_count unchanged.
- br_taken=1 during a 2-cycle dmem stall → no resets during the stall; flush happens in the resp cycle.
- Preload stall_count=FFFF and hold a stall → stays FFFF. stat_clear → 0. Assert reset while in HOLD_D → state RUN, all outputs 0, counters 0.
